// File: rtl/boot_pkg.sv
`default_nettype none
// ============================================================================
// Module : boot_pkg
// Brief  : Shared constants and state encodings for the IMEM UART boot loader.
// Rev    : 1.0
// ============================================================================
package boot_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LEN_H   = 3'd1,
      S_LEN_L   = 3'd2,
      S_DATA_LO = 3'd3,
      S_DATA_HI = 3'd4,
      S_CSUM    = 3'd5,
      S_DONE    = 3'd6,
      S_ERR     = 3'd7
   } boot_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   // Mid-bit offset in clock cycles, used to centre the start-bit check.
   function automatic int half_bit(input int clk_div);
      return clk_div / 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module : uart_rx
// Brief  : 8N1 UART receiver; start-bit glitch filter, mid-bit sampling.
// Rev    : 1.0
// ============================================================================
module uart_rx
   import boot_pkg::*;
#(
   parameter int CLK_DIV = 434
)(
   input  logic       CLK,
   input  logic       RST,
   input  logic       RXD,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       rx_ferr
);

   localparam int               CNT_W      = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] C_BIT_END  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] C_HALF_END = CNT_W'(half_bit(CLK_DIV) - 1);

   rx_state_t        r_state;
   logic             r_rxd_q;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit;
   logic [7:0]       r_shift;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state  <= RX_IDLE;
         r_rxd_q  <= 1'b1;
         r_cnt    <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         rx_valid <= 1'b0;
         rx_data  <= '0;
         rx_ferr  <= 1'b0;
      end else begin
         r_rxd_q  <= RXD;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
         case (r_state)
            RX_IDLE: begin
               if (r_rxd_q && !RXD) begin
                  r_state <= RX_START;
                  r_cnt   <= '0;
               end
            end
            RX_START: begin
               // A line already back high at mid start bit was only a glitch.
               if (r_cnt == C_HALF_END) begin
                  r_cnt   <= '0;
                  r_bit   <= '0;
                  r_state <= RXD ? RX_IDLE : RX_DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (r_cnt == C_BIT_END) begin
                  r_cnt   <= '0;
                  r_shift <= {RXD, r_shift[7:1]};
                  r_bit   <= r_bit + 1'b1;
                  if (r_bit == 3'd7)
                     r_state <= RX_STOP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (r_cnt == C_BIT_END) begin
                  r_cnt   <= '0;
                  r_state <= RX_IDLE;
                  if (RXD) begin
                     rx_valid <= 1'b1;
                     rx_data  <= r_shift;
                  end else begin
                     rx_ferr <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= RX_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module : imem_boot_loader
// Brief  : UART boot loader writing a framed image into IMEM; holds core in
//          reset until loaded. Define BOOT_CSUM_EN for the trailing XOR check.
// Rev    : 1.0
// ============================================================================
module imem_boot_loader
   import boot_pkg::*;
#(
   parameter int CLK_DIV   = 434,
   parameter int ADDR_W    = 10,
   parameter int MAX_WORDS = 1024
)(
   input  logic              CLK,
   input  logic              RST,
   input  logic              RXD,
   output logic [ADDR_W-1:0] IMEM_ADDR,
   output logic              IMEM_WEN,
   output logic [15:0]       IMEM_DI,
   output logic              CORE_RST,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR
);

   localparam logic [16:0] C_MAX_WORDS = 17'(MAX_WORDS);

   logic r_rxd_s1, r_rxd_s2;
   logic w_rx_valid, w_rx_ferr;
   logic [7:0] w_rx_data;

   boot_state_t       r_state;
   logic [7:0]        r_len_h;
   logic [15:0]       r_len;
   logic [ADDR_W:0]   r_wcnt;
   logic [7:0]        r_lo;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_di;
   logic              r_wen, r_core_rst, r_busy, r_done, r_err;
   logic [16:0]       w_len_rx;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_rxd_s1 <= 1'b1;
         r_rxd_s2 <= 1'b1;
      end else begin
         r_rxd_s1 <= RXD;
         r_rxd_s2 <= r_rxd_s1;
      end
   end

   uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
      .CLK      (CLK),
      .RST      (RST),
      .RXD      (r_rxd_s2),
      .rx_valid (w_rx_valid),
      .rx_data  (w_rx_data),
      .rx_ferr  (w_rx_ferr)
   );

   assign w_len_rx = {1'b0, r_len_h, w_rx_data};

`ifdef BOOT_CSUM_EN
   logic [7:0] r_xor;
   logic       w_last_wr;
   assign w_last_wr = (17'(r_wcnt) + 17'd1) == {1'b0, r_len};
`else
   logic w_all_wr;
   assign w_all_wr = 17'(r_wcnt) == {1'b0, r_len};
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= S_IDLE;
         r_len_h    <= '0;
         r_len      <= '0;
         r_wcnt     <= '0;
         r_lo       <= '0;
         r_addr     <= '0;
         r_di       <= '0;
         r_wen      <= 1'b0;
         r_core_rst <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
`ifdef BOOT_CSUM_EN
         r_xor      <= '0;
`endif
      end else begin
         r_wen <= 1'b0;
         if (w_rx_ferr && r_busy) begin
            r_state    <= S_ERR;
            r_busy     <= 1'b0;
            r_err      <= 1'b1;
            r_core_rst <= 1'b1;
         end else begin
            case (r_state)
               S_IDLE, S_DONE: begin
                  if (w_rx_valid && w_rx_data == SYNC_BYTE) begin
                     r_state    <= S_LEN_H;
                     r_busy     <= 1'b1;
                     r_done     <= 1'b0;
                     r_core_rst <= 1'b1;
                     r_wcnt     <= '0;
`ifdef BOOT_CSUM_EN
                     r_xor      <= '0;
`endif
                  end
               end
               S_LEN_H: begin
                  if (w_rx_valid) begin
                     r_len_h <= w_rx_data;
                     r_state <= S_LEN_L;
                  end
               end
               S_LEN_L: begin
                  if (w_rx_valid) begin
                     r_len  <= w_len_rx[15:0];
                     r_wcnt <= '0;
                     if (w_len_rx > C_MAX_WORDS) begin
                        r_state <= S_ERR;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                     end else if (w_len_rx == 17'd0) begin
`ifdef BOOT_CSUM_EN
                        r_state    <= S_CSUM;
`else
                        r_state    <= S_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_core_rst <= 1'b0;
`endif
                     end else begin
                        r_state <= S_DATA_LO;
                     end
                  end
               end
               S_DATA_LO: begin
`ifndef BOOT_CSUM_EN
                  // Reached once more after the final write; finish here.
                  if (w_all_wr) begin
                     r_state    <= S_DONE;
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                     r_core_rst <= 1'b0;
                  end else
`endif
                  if (w_rx_valid) begin
                     r_lo    <= w_rx_data;
                     r_state <= S_DATA_HI;
`ifdef BOOT_CSUM_EN
                     r_xor   <= r_xor ^ w_rx_data;
`endif
                  end
               end
               S_DATA_HI: begin
                  if (w_rx_valid) begin
                     r_wen  <= 1'b1;
                     r_addr <= r_wcnt[ADDR_W-1:0];
                     r_di   <= {w_rx_data, r_lo};
                     r_wcnt <= r_wcnt + 1'b1;
`ifdef BOOT_CSUM_EN
                     r_xor   <= r_xor ^ w_rx_data;
                     r_state <= w_last_wr ? S_CSUM : S_DATA_LO;
`else
                     r_state <= S_DATA_LO;
`endif
                  end
               end
`ifdef BOOT_CSUM_EN
               S_CSUM: begin
                  if (w_rx_valid) begin
                     r_busy <= 1'b0;
                     if (w_rx_data == r_xor) begin
                        r_state    <= S_DONE;
                        r_done     <= 1'b1;
                        r_core_rst <= 1'b0;
                     end else begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                     end
                  end
               end
`endif
               S_ERR: r_state <= S_ERR;
               default: begin
                  r_state <= S_ERR;
                  r_busy  <= 1'b0;
                  r_err   <= 1'b1;
               end
            endcase
         end
      end
   end

   // The IMEM port mux itself sits outside; CORE_RST selects this block.
   assign IMEM_ADDR = r_addr;
   assign IMEM_WEN  = r_wen;
   assign IMEM_DI   = r_di;
   assign CORE_RST  = r_core_rst;
   assign BUSY      = r_busy;
   assign DONE      = r_done;
   assign ERR       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_imem_boot_loader
// Brief  : Byte-level vector table plus glitch and write-latency sequences.
// Rev    : 1.0
// ============================================================================
module tb_imem_boot_loader;

   localparam int CLK_DIV   = 16;
   localparam int ADDR_W    = 10;
   localparam int MAX_WORDS = 1024;
`ifdef BOOT_CSUM_EN
   localparam bit CSUM_BUILD = 1'b1;
`else
   localparam bit CSUM_BUILD = 1'b0;
`endif

   // Status nibble {BUSY, DONE, ERR, CORE_RST}
   localparam bit [3:0] ID = 4'b0001;
   localparam bit [3:0] BS = 4'b1001;
   localparam bit [3:0] DN = 4'b0100;
   localparam bit [3:0] ER = 4'b0011;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rxd = 1'b1;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_wen;
   logic [15:0]       imem_di;
   logic              core_rst, busy, done, err;

   always #5 clk = ~clk;

   imem_boot_loader #(
      .CLK_DIV   (CLK_DIV),
      .ADDR_W    (ADDR_W),
      .MAX_WORDS (MAX_WORDS)
   ) u_dut (
      .CLK       (clk),
      .RST       (rst),
      .RXD       (rxd),
      .IMEM_ADDR (imem_addr),
      .IMEM_WEN  (imem_wen),
      .IMEM_DI   (imem_di),
      .CORE_RST  (core_rst),
      .BUSY      (busy),
      .DONE      (done),
      .ERR       (err)
   );

   typedef struct {
      bit [ADDR_W-1:0] addr;
      bit [15:0]       data;
   } wr_t;

   typedef struct {
      bit        rst;
      bit [7:0]  b;
      bit        stop_low;
      bit [3:0]  exp_csum;
      bit [3:0]  exp_nocsum;
      int        nwr;
      bit [15:0] waddr;
      bit [15:0] wdata;
   } vec_t;

   wr_t  wq[$];
   vec_t vt[$];
   int   checks = 0;
   int   failures = 0;
   int   lat_err = 0;
   int   rxv_cnt = 0;
   logic rxv_prev = 1'b0;

   // Every write must land exactly one cycle after a received byte.
   always @(negedge clk) begin
      if (imem_wen) begin
         wq.push_back('{addr: imem_addr, data: imem_di});
         if (!rxv_prev) lat_err++;
      end
      if (u_dut.w_rx_valid) rxv_cnt++;
      rxv_prev = u_dut.w_rx_valid;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_low);
      @(negedge clk);
      rxd = 1'b0;
      repeat (CLK_DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CLK_DIV) @(negedge clk);
      end
      rxd = ~stop_low;
      repeat (CLK_DIV) @(negedge clk);
      rxd = 1'b1;
      repeat (2 * CLK_DIV) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic add(input bit r, input bit [7:0] b, input bit sl, input bit [3:0] ec,
                      input bit [3:0] en, input int nwr, input bit [15:0] wa, input bit [15:0] wd);
      vt.push_back('{rst: r, b: b, stop_low: sl, exp_csum: ec, exp_nocsum: en,
                     nwr: nwr, waddr: wa, wdata: wd});
   endtask

   task automatic byte_in(input bit [7:0] b, input bit [3:0] ec, input bit [3:0] en);
      add(1'b0, b, 1'b0, ec, en, 0, 16'h0, 16'h0);
   endtask

   task automatic byte_wr(input bit [7:0] b, input bit [3:0] ec, input bit [3:0] en,
                          input bit [15:0] wa, input bit [15:0] wd);
      add(1'b0, b, 1'b0, ec, en, 1, wa, wd);
   endtask

   task automatic rst_in();
      add(1'b1, 8'h00, 1'b0, ID, ID, 0, 16'h0, 16'h0);
   endtask

   // Good two-word image: XOR of 34 12 78 56 is 0x08.
   task automatic good_image();
      rst_in();
      byte_in(8'hA5, BS, BS);
      byte_in(8'h00, BS, BS);
      byte_in(8'h02, BS, BS);
      byte_in(8'h34, BS, BS);
      byte_wr(8'h12, BS, BS, 16'd0, 16'h1234);
      byte_in(8'h78, BS, BS);
      byte_wr(8'h56, BS, DN, 16'd1, 16'h5678);
      byte_in(8'h08, DN, DN);
   endtask

   initial begin
      int   n0;
      vec_t v;
      bit [3:0] exp;

      good_image();
      // Bad checksum (correct 0x33), then a sync byte that ERR must ignore
      rst_in();
      byte_in(8'hA5, BS, BS);
      byte_in(8'h00, BS, BS);
      byte_in(8'h01, BS, BS);
      byte_in(8'h11, BS, BS);
      byte_wr(8'h22, BS, DN, 16'd0, 16'h2211);
      byte_in(8'h00, ER, DN);
      byte_in(8'hA5, ER, BS);
      // Leading junk, then N = 1025
      rst_in();
      byte_in(8'h00, ID, ID);
      byte_in(8'hFF, ID, ID);
      byte_in(8'hA5, BS, BS);
      byte_in(8'h04, BS, BS);
      byte_in(8'h01, ER, ER);
      // N = 1024 is still accepted
      rst_in();
      byte_in(8'hA5, BS, BS);
      byte_in(8'h04, BS, BS);
      byte_in(8'h00, BS, BS);
      // Empty image, then a reload
      rst_in();
      byte_in(8'hA5, BS, BS);
      byte_in(8'h00, BS, BS);
      byte_in(8'h00, BS, DN);
      byte_in(8'h00, DN, DN);
      byte_in(8'hA5, BS, BS);
      byte_in(8'h00, BS, BS);
      byte_in(8'h01, BS, BS);
      byte_in(8'hAA, BS, BS);
      byte_wr(8'hBB, BS, DN, 16'd0, 16'hBBAA);
      byte_in(8'h11, DN, DN);
      // Framing error on the second data byte
      rst_in();
      byte_in(8'hA5, BS, BS);
      byte_in(8'h00, BS, BS);
      byte_in(8'h02, BS, BS);
      byte_in(8'h11, BS, BS);
      add(1'b0, 8'h22, 1'b1, ER, ER, 0, 16'h0, 16'h0);
      // Reset after the third data byte, then a full re-send
      rst_in();
      byte_in(8'hA5, BS, BS);
      byte_in(8'h00, BS, BS);
      byte_in(8'h02, BS, BS);
      byte_in(8'h34, BS, BS);
      byte_wr(8'h12, BS, BS, 16'd0, 16'h1234);
      byte_in(8'h78, BS, BS);
      good_image();

      for (int i = 0; i < vt.size(); i++) begin
         v = vt[i];
         if (v.rst) begin
            do_reset();
            check($sformatf("rst_status[%0d]", i), {28'd0, busy, done, err, core_rst}, {28'd0, ID});
            check($sformatf("rst_imem[%0d]", i), {5'd0, imem_addr, imem_di, imem_wen}, 32'd0);
         end else begin
            n0 = wq.size();
            send_byte(v.b, v.stop_low);
            exp = CSUM_BUILD ? v.exp_csum : v.exp_nocsum;
            check($sformatf("status[%0d] byte %02h", i, v.b), {28'd0, busy, done, err, core_rst}, {28'd0, exp});
            check($sformatf("nwrites[%0d]", i), wq.size() - n0, v.nwr);
            if (v.nwr > 0 && wq.size() > 0) begin
               check($sformatf("waddr[%0d]", i), {22'd0, wq[$].addr}, {16'd0, v.waddr});
               check($sformatf("wdata[%0d]", i), {16'd0, wq[$].data}, {16'd0, v.wdata});
            end
         end
      end

      // 0.3-bit low glitch in IDLE must not produce a byte
      do_reset();
      n0 = rxv_cnt;
      rxd = 1'b0;
      repeat (5) @(negedge clk);
      rxd = 1'b1;
      repeat (12 * CLK_DIV) @(negedge clk);
      check("glitch_rx_valid", rxv_cnt - n0, 0);
      check("glitch_status", {28'd0, busy, done, err, core_rst}, {28'd0, ID});

      check("write_latency", lat_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
